// File: rtl/pearson_msg_serializer.sv
// rtl/pearson_msg_serializer.sv - message block to byte stream serializer for the Pearson hash stage
// Emits one byte per downstream handshake, flagging first/last bytes, with a done pulse per message.
module pearson_msg_serializer #(
  parameter int MSG_BYTES = 8
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [8*MSG_BYTES-1:0]         msg_in,
  input  logic [$clog2(MSG_BYTES+1)-1:0] msg_len,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           abort,
  output logic [7:0]                     byte_out,
  output logic                           byte_valid,
  output logic                           byte_first,
  output logic                           byte_last,
  input  logic                           byte_ready,
  output logic [$clog2(MSG_BYTES+1)-1:0] byte_count,
  output logic                           done,
  output logic                           busy
);

  localparam int LEN_W = $clog2(MSG_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [8*MSG_BYTES-1:0] shreg;
  logic [LEN_W-1:0]       remaining;
  logic [LEN_W-1:0]       count_q;
  logic                   out_of_reset;
  logic [LEN_W-1:0]       eff_len;

  // Out-of-range lengths fall back to a full block rather than being rejected.
  always_comb begin
    eff_len = msg_len;
    if (msg_len == '0 || msg_len > LEN_W'(MSG_BYTES))
      eff_len = LEN_W'(MSG_BYTES);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      shreg        <= '0;
      remaining    <= '0;
      count_q      <= '0;
      out_of_reset <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
      case (state)
        IDLE: begin
          if (in_valid && in_ready && !abort) begin
            shreg     <= msg_in;
            remaining <= eff_len;
            count_q   <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (abort) begin
            shreg     <= '0;
            remaining <= '0;
            count_q   <= '0;
            state     <= IDLE;
          end else if (byte_ready) begin
            shreg     <= shreg >> 8;
            remaining <= remaining - LEN_W'(1);
            count_q   <= count_q + LEN_W'(1);
            if (remaining == LEN_W'(1))
              state <= DONE;
          end
        end
        DONE: begin
          if (abort)
            count_q <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of registered state, so they never depend on current inputs.
  assign in_ready   = (state == IDLE) && out_of_reset;
  assign byte_valid = (state == SEND);
  assign byte_out   = (state == SEND) ? shreg[7:0] : 8'h00;
  assign byte_first = (state == SEND) && (count_q == '0);
  assign byte_last  = (state == SEND) && (remaining == LEN_W'(1));
  assign byte_count = count_q;
  assign done       = (state == DONE);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_pearson_msg_serializer.sv
// tb/tb_pearson_msg_serializer.sv - directed-vector bench for pearson_msg_serializer
module tb_pearson_msg_serializer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [63:0] msg_in;
  logic [3:0]  msg_len;
  logic        in_valid;
  logic        in_ready;
  logic        abort;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_first;
  logic        byte_last;
  logic        byte_ready;
  logic [3:0]  byte_count;
  logic        done;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  pearson_msg_serializer #(.MSG_BYTES(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .msg_in     (msg_in),
    .msg_len    (msg_len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .abort      (abort),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_first (byte_first),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .byte_count (byte_count),
    .done       (done),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic [63:0] data, input logic [3:0] len);
    int cyc = 0;
    while (!in_ready && cyc < 20) begin
      tick();
      cyc++;
    end
    check_eq("in_ready_before_offer", 32'(in_ready), 1);
    msg_in   = data;
    msg_len  = len;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    msg_in   = '1;
  endtask

  // n is the hand-derived effective length; stall gives byte_ready pattern 1,0,0,1,0,0,...
  task automatic send_msg(input string tag, input logic [63:0] data, input logic [3:0] len,
                          input int n, input bit stall);
    int k = 0;
    int cyc = 0;
    logic [7:0] exp_b;
    logic [63:0] d;
    d = data;
    offer(data, len);
    check_eq({tag, "_first_latency"}, 32'(byte_valid), 1);
    while (k < n && cyc < 200) begin
      byte_ready = stall ? (cyc % 3 == 0) : 1'b1;
      exp_b = d[8*k +: 8];
      check_eq({tag, "_byte_out"}, 32'(byte_out), 32'(exp_b));
      check_eq({tag, "_first"}, 32'(byte_first), 32'(k == 0));
      check_eq({tag, "_last"}, 32'(byte_last), 32'(k == n - 1));
      if (byte_ready) begin
        check_eq({tag, "_valid"}, 32'(byte_valid), 1);
        k++;
      end
      tick();
      cyc++;
    end
    byte_ready = 1'b1;
    check_eq({tag, "_bytes_sent"}, 32'(k), 32'(n));
    check_eq({tag, "_done"}, 32'(done), 1);
    check_eq({tag, "_valid_in_done"}, 32'(byte_valid), 0);
    check_eq({tag, "_byte_count"}, 32'(byte_count), 32'(n));
    tick();
    check_eq({tag, "_done_one_cycle"}, 32'(done), 0);
    check_eq({tag, "_in_ready_after"}, 32'(in_ready), 1);
    check_eq({tag, "_count_held"}, 32'(byte_count), 32'(n));
  endtask

  initial begin
    reset_n    = 1'b0;
    msg_in     = '0;
    msg_len    = '0;
    in_valid   = 1'b0;
    abort      = 1'b0;
    byte_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_valid", 32'(byte_valid), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_out", 32'(byte_out), 0);
    check_eq("rst_count", 32'(byte_count), 0);
    reset_n = 1'b1;
    tick();
    check_eq("rst_in_ready", 32'(in_ready), 1);

    send_msg("t1_full", 64'h0807060504030201, 4'd8, 8, 1'b0);
    send_msg("t2_len3", 64'hFFFFFFFFFFAA5511, 4'd3, 3, 1'b0);
    send_msg("t3_len1", 64'hFFFFFFFFFFFFFF7E, 4'd1, 1, 1'b0);
    send_msg("t4_stall", 64'h0807060504030201, 4'd8, 8, 1'b1);
    send_msg("t5_len0", 64'h1122334455667788, 4'd0, 8, 1'b0);
    send_msg("t5_len9", 64'h99AABBCCDDEEFF00, 4'd9, 8, 1'b0);

    // abort while the 4th byte is on the stream
    offer(64'h0807060504030201, 4'd8);
    repeat (3) tick();
    check_eq("abort_4th_byte", 32'(byte_out), 32'h04);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_valid", 32'(byte_valid), 0);
    check_eq("abort_done", 32'(done), 0);
    check_eq("abort_count", 32'(byte_count), 0);
    check_eq("abort_busy", 32'(busy), 0);
    tick();
    check_eq("abort_no_done", 32'(done), 0);
    check_eq("abort_in_ready", 32'(in_ready), 1);

    // abort in IDLE blocks capture
    msg_in = 64'h0807060504030201;
    msg_len = 4'd8;
    in_valid = 1'b1;
    abort = 1'b1;
    tick();
    in_valid = 1'b0;
    abort = 1'b0;
    check_eq("idle_abort_busy", 32'(busy), 0);
    check_eq("idle_abort_valid", 32'(byte_valid), 0);

    // reset mid-message, then a normal message
    offer(64'h0807060504030201, 4'd8);
    repeat (2) tick();
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(byte_valid), 0);
    check_eq("midrst_out", 32'(byte_out), 0);
    check_eq("midrst_busy", 32'(busy), 0);
    check_eq("midrst_count", 32'(byte_count), 0);
    check_eq("midrst_first", 32'(byte_first), 0);
    check_eq("midrst_last", 32'(byte_last), 0);
    tick();
    reset_n = 1'b1;
    tick();
    send_msg("t6_after_rst", 64'hFFFFFFFFFFAA5511, 4'd3, 3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
